fir_lanes_mac: RTL and testbench

- Next-generation FIR filter block with a single time-multiplexed signed MAC.
- Each handshake word carries LANES packed samples; they are filtered in order through a NR_STAGES-tap delay line.
- Fetches input words from the source and presents packed results to the sink using 4-phase req/ack on both sides.
- Adds a coefficient-load strobe, a bypass mode, round/saturate and a sticky saturation flag.

---
 rtl/fir_lanes_mac.sv | 166 ++++++++++++++++
 tb/tb_fir_lanes_mac.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_lanes_mac.sv
// Time-multiplexed FIR filter: one signed MAC serves LANES packed samples per
// 4-phase handshake word. Includes coefficient load, bypass and round/saturate.
module fir_lanes_mac #(
  parameter int NR_STAGES = 32,
  parameter int DWIDTH    = 16,
  parameter int LANES     = 2,
  parameter int LWIDTH    = LANES * DWIDTH,
  parameter int CWIDTH    = NR_STAGES * DWIDTH,
  parameter int ACCW      = 2 * DWIDTH + $clog2(NR_STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_in,
  input  logic              ack_in,
  input  logic [0:LWIDTH-1] data_in,
  output logic              req_out,
  input  logic              ack_out,
  output logic [0:LWIDTH-1] data_out,
  input  logic [0:CWIDTH-1] h_in,
  input  logic              coef_ld,
  input  logic              bypass,
  output logic              sat_sticky
);

  localparam int TAP_W  = $clog2(NR_STAGES);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(NR_STAGES - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic signed [ACCW:0] RND_HALF = (ACCW + 1)'(2 ** (DWIDTH - 2));
  localparam logic signed [ACCW:0] Y_MAX    = (ACCW + 1)'(2 ** (DWIDTH - 1) - 1);
  localparam logic signed [ACCW:0] Y_MIN    = -((ACCW + 1)'(2 ** (DWIDTH - 1)));

  typedef enum logic [2:0] {
    S_FETCH, S_WAIT_IN, S_SHIFT, S_MAC, S_ROUND, S_OUT, S_WAIT_OUT
  } state_t;

  state_t state, state_next;

  logic signed [DWIDTH-1:0] x [NR_STAGES];
  logic signed [DWIDTH-1:0] h [NR_STAGES];
  logic signed [ACCW-1:0]   acc;
  logic [TAP_W-1:0]         tap;
  logic [LANE_W-1:0]        lane;
  logic [0:LWIDTH-1]        in_word;
  logic [0:LWIDTH-1]        out_buf;
  logic                     byp;

  logic signed [2*DWIDTH-1:0] prod;
  logic signed [ACCW:0]       rnd;
  logic signed [ACCW:0]       shifted;
  logic [DWIDTH-1:0]          y;
  logic                       sat;
  logic [DWIDTH-1:0]          lane_sample;
  logic [0:LWIDTH-1]          out_next;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (req_in && ack_in) state_next = S_WAIT_IN;
      S_WAIT_IN:  if (!ack_in) state_next = byp ? S_OUT : S_SHIFT;
      S_SHIFT:    state_next = S_MAC;
      S_MAC:      if (tap == LAST_TAP) state_next = S_ROUND;
      S_ROUND:    state_next = (lane == LAST_LANE) ? S_OUT : S_SHIFT;
      S_OUT:      if (ack_out) state_next = S_WAIT_OUT;
      S_WAIT_OUT: if (!ack_out) state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  // Round half-up at the Q1.(DWIDTH-1) point, then clamp to the sample range.
  always_comb begin
    prod    = h[tap] * x[tap];
    rnd     = {acc[ACCW-1], acc} + RND_HALF;
    shifted = rnd >>> (DWIDTH - 1);
    sat     = 1'b0;
    if (shifted > Y_MAX) begin
      y   = Y_MAX[DWIDTH-1:0];
      sat = 1'b1;
    end else if (shifted < Y_MIN) begin
      y   = Y_MIN[DWIDTH-1:0];
      sat = 1'b1;
    end else begin
      y = shifted[DWIDTH-1:0];
    end
  end

  always_comb begin
    lane_sample = '0;
    out_next    = out_buf;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane == LANE_W'(i)) begin
        lane_sample                  = in_word[i*DWIDTH +: DWIDTH];
        out_next[i*DWIDTH +: DWIDTH] = y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_in     <= 1'b0;
      req_out    <= 1'b0;
      data_out   <= '0;
      sat_sticky <= 1'b0;
      acc        <= '0;
      tap        <= '0;
      lane       <= '0;
      in_word    <= '0;
      out_buf    <= '0;
      byp        <= 1'b0;
      for (int unsigned k = 0; k < NR_STAGES; k++) begin
        x[k] <= '0;
        h[k] <= '0;
      end
    end else begin
      // req_in is registered, so an acknowledge is only taken once it is high.
      req_in <= (state_next == S_FETCH);
      case (state)
        S_FETCH: begin
          if (req_in && ack_in) begin
            in_word <= data_in;
            byp     <= bypass;
            lane    <= '0;
          end else if (!ack_in && coef_ld) begin
            for (int unsigned k = 0; k < NR_STAGES; k++)
              h[k] <= h_in[k*DWIDTH +: DWIDTH];
            sat_sticky <= 1'b0;
          end
        end
        S_WAIT_IN: begin
          if (!ack_in && byp) begin
            data_out <= in_word;
            req_out  <= 1'b1;
          end
        end
        S_SHIFT: begin
          x[0] <= lane_sample;
          for (int unsigned k = 1; k < NR_STAGES; k++) x[k] <= x[k-1];
          acc <= '0;
          tap <= '0;
        end
        S_MAC: begin
          acc <= acc + ACCW'(prod);
          tap <= tap + 1'b1;
        end
        S_ROUND: begin
          out_buf <= out_next;
          if (sat) sat_sticky <= 1'b1;
          if (lane == LAST_LANE) begin
            data_out <= out_next;
            req_out  <= 1'b1;
          end else begin
            lane <= lane + 1'b1;
          end
        end
        S_OUT: if (ack_out) req_out <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_lanes_mac.sv
// Directed and randomized checks of fir_lanes_mac against an arithmetic
// reference filter (sample history array, sum of products, round, clamp).
module tb_fir_lanes_mac;
  localparam int N  = 32;
  localparam int D  = 16;
  localparam int L  = 2;
  localparam int LW = L * D;
  localparam int CW = N * D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_in;
  logic          ack_in = 1'b0;
  logic [0:LW-1] data_in = '0;
  logic          req_out;
  logic          ack_out = 1'b0;
  logic [0:LW-1] data_out;
  logic [0:CW-1] h_in = '0;
  logic          coef_ld = 1'b0;
  logic          bypass = 1'b0;
  logic          sat_sticky;

  fir_lanes_mac #(.NR_STAGES(N), .DWIDTH(D), .LANES(L)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_in(ack_in), .data_in(data_in),
    .req_out(req_out), .ack_out(ack_out), .data_out(data_out), .h_in(h_in),
    .coef_ld(coef_ld), .bypass(bypass), .sat_sticky(sat_sticky)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int hm [N];
  int xm [N];
  int hnew [N];
  bit stk_m = 1'b0;
  logic [0:LW-1] exp_word;
  logic [0:LW-1] got;
  localparam int FILT_LAT = 1 + L * (N + 2);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      hm[k] = 0;
      xm[k] = 0;
    end
    stk_m = 1'b0;
  endtask

  task automatic model_step(input logic [D-1:0] s, output logic [D-1:0] yv);
    longint a;
    longint r;
    for (int k = N - 1; k > 0; k--) xm[k] = xm[k-1];
    xm[0] = int'($signed(s));
    a = 0;
    for (int k = 0; k < N; k++) a += longint'(hm[k]) * longint'(xm[k]);
    r = (a + (longint'(1) << (D - 2))) >>> (D - 1);
    if (r > 32767) begin
      r = 32767;
      stk_m = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      stk_m = 1'b1;
    end
    yv = r[D-1:0];
  endtask

  task automatic wait_req_in(input string tag);
    int n = 0;
    while (req_in !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(req_in), 64'd1);
  endtask

  task automatic load_coefs();
    wait_req_in("load_req_in");
    for (int k = 0; k < N; k++) h_in[k*D +: D] = D'(hnew[k]);
    coef_ld = 1'b1;
    @(negedge clk);
    coef_ld = 1'b0;
    for (int k = 0; k < N; k++) hm[k] = hnew[k];
    stk_m = 1'b0;
  endtask

  task automatic send(input logic [0:LW-1] w, input bit byp);
    logic [D-1:0] yv;
    wait_req_in("send_req_in");
    data_in = w;
    bypass  = byp;
    ack_in  = 1'b1;
    @(negedge clk);
    ack_in  = 1'b0;
    bypass  = ~byp;
    data_in = $urandom;
    if (byp) exp_word = w;
    else begin
      for (int i = 0; i < L; i++) begin
        model_step(w[i*D +: D], yv);
        exp_word[i*D +: D] = yv;
      end
    end
  endtask

  task automatic recv(input string tag, input int stall, input int exp_lat,
                      output logic [0:LW-1] obs);
    int n = 0;
    bit stable = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (req_out !== 1'b1 && n < 500);
    chk({tag, "_req_out"}, 64'(req_out), 64'd1);
    if (exp_lat >= 0) chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    obs = data_out;
    chk({tag, "_data"}, 64'(data_out), 64'(exp_word));
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (data_out !== obs || req_in !== 1'b0 || req_out !== 1'b1) stable = 1'b0;
      end
      chk({tag, "_hold"}, 64'(stable), 64'd1);
    end
    ack_out = 1'b1;
    @(negedge clk);
    chk({tag, "_req_out_drop"}, 64'(req_out), 64'd0);
    ack_out = 1'b0;
    @(negedge clk);
    chk({tag, "_sticky"}, 64'(sat_sticky), 64'(stk_m));
  endtask

  task automatic set_all_coefs(input int v);
    for (int k = 0; k < N; k++) hnew[k] = v;
  endtask

  task automatic set_impulse_coefs();
    set_all_coefs(0);
    hnew[0] = 32'h4000;
    hnew[1] = 32'h2000;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_in", 64'(req_in), 64'd0);
    chk("rst_req_out", 64'(req_out), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_sticky", 64'(sat_sticky), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_in", 64'(req_in), 64'd1);

    // Impulse response with latency check
    set_impulse_coefs();
    load_coefs();
    send({16'h4000, 16'h0000}, 1'b0);
    recv("imp0", 0, FILT_LAT, got);
    chk("imp0_value", 64'(got), 64'h2000_1000);
    send({16'h0000, 16'h0000}, 1'b0);
    recv("imp1", 0, -1, got);
    chk("imp1_value", 64'(got), 64'h0);

    // Positive then negative saturation
    set_all_coefs(32'h7FFF);
    load_coefs();
    for (int i = 0; i < 17; i++) begin
      send({16'h7FFF, 16'h7FFF}, 1'b0);
      recv("satp", 0, -1, got);
    end
    chk("satp_value", 64'(got), 64'h7FFF_7FFF);
    chk("satp_sticky", 64'(sat_sticky), 64'd1);
    for (int i = 0; i < 17; i++) begin
      send({16'h8000, 16'h8000}, 1'b0);
      recv("satn", 0, -1, got);
    end
    chk("satn_value", 64'(got), 64'h8000_8000);

    // coef_ld mid-MAC is ignored; sticky survives it
    send({16'h1111, 16'h8000}, 1'b0);
    repeat (10) @(negedge clk);
    for (int k = 0; k < N; k++) h_in[k*D +: D] = 16'h0001;
    coef_ld = 1'b1;
    @(negedge clk);
    coef_ld = 1'b0;
    recv("cld_mac", 0, -1, got);
    chk("cld_mac_sticky_kept", 64'(sat_sticky), 64'd1);

    // coef_ld in fetch applies and clears sticky
    set_impulse_coefs();
    load_coefs();
    @(negedge clk);
    chk("cld_fetch_sticky_clr", 64'(sat_sticky), 64'd0);

    // Bypass leaves the delay line untouched
    send(32'h1234ABCD, 1'b1);
    recv("byp", 0, 1, got);
    send({16'h0000, 16'h0000}, 1'b0);
    recv("after_byp", 0, FILT_LAT, got);
    chk("after_byp_value", 64'(got), 64'hE000_0000);

    // Backpressure: sink stalls for 50 cycles
    send({16'h2000, 16'hC000}, 1'b0);
    recv("stall", 50, -1, got);
    repeat (5) @(negedge clk);
    chk("stall_no_extra_word", 64'(req_out), 64'd0);

    // Reset during MAC aborts everything
    send({16'h7000, 16'h7000}, 1'b0);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("mid_rst_req_out", 64'(req_out), 64'd0);
    chk("mid_rst_data_out", 64'(data_out), 64'd0);
    @(negedge clk);
    chk("mid_rst_req_in", 64'(req_in), 64'd1);
    chk("mid_rst_req_out2", 64'(req_out), 64'd0);
    set_impulse_coefs();
    load_coefs();
    send({16'h4000, 16'h0000}, 1'b0);
    recv("rst_imp0", 0, FILT_LAT, got);
    chk("rst_imp0_value", 64'(got), 64'h2000_1000);
    send({16'h0000, 16'h0000}, 1'b0);
    recv("rst_imp1", 0, -1, got);
    chk("rst_imp1_value", 64'(got), 64'h0);

    // Randomized words, coefficients, bypass and stalls
    for (int k = 0; k < N; k++) hnew[k] = int'($urandom_range(0, 8191)) - 4096;
    load_coefs();
    for (int i = 0; i < 24; i++) begin
      send(LW'($urandom), ($urandom_range(0, 3) == 0));
      recv("rand", int'($urandom_range(0, 3)), -1, got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
